// File: rtl/minibus_arbiter.sv
// minibus_arbiter: round-robin arbiter sharing one minibus slave port among N_MASTERS requesters;
// registers the winning request, routes the response back, and converts a hung slave into an error.
module minibus_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [N_MASTERS-1:0]            m_ren,
    input  logic [N_MASTERS-1:0]            m_wen,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
    input  logic [N_MASTERS*2-1:0]          m_width,
    output logic [N_MASTERS-1:0]            m_ack,
    output logic [N_MASTERS-1:0]            m_err,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic                            s_sel,
    output logic                            s_ren,
    output logic                            s_wen,
    output logic [ADDR_WIDTH-1:0]           s_addr,
    output logic [DATA_WIDTH-1:0]           s_wdata,
    output logic [1:0]                      s_width,
    input  logic                            s_ack,
    input  logic                            s_err,
    input  logic [DATA_WIDTH-1:0]           s_rdata,
    output logic [$clog2(N_MASTERS)-1:0]    grant_id,
    output logic                            busy
);
    localparam int GW = $clog2(N_MASTERS);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 r_state, w_next;
    logic [GW-1:0]          r_last, r_gid, w_win, w_idx;
    logic [CW-1:0]          r_cnt;
    logic                   r_ren, r_wen;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [1:0]             r_width;
    logic [N_MASTERS-1:0]   w_req, w_onehot;
    logic                   w_any, w_busy, w_tmo, w_done;

    assign w_req    = m_ren | m_wen;
    assign w_busy   = (r_state == BUSY);
    assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
    assign w_done   = w_busy && (s_ack || s_err || w_tmo);
    assign w_onehot = {{(N_MASTERS-1){1'b0}}, 1'b1} << r_gid;

    // Scan from farthest to nearest so the requester closest after r_last is the final assignment.
    always_comb begin
        w_win = r_last;
        w_any = 1'b0;
        w_idx = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            w_idx = GW'((int'(r_last) + k) % N_MASTERS);
            if (w_req[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_any)
            w_next = BUSY;
        else if (w_done)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_last  <= GW'(N_MASTERS - 1);
            r_gid   <= '0;
            r_cnt   <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_width <= '0;
        end else if (!w_busy && w_any) begin
            r_last  <= w_win;
            r_gid   <= w_win;
            r_cnt   <= '0;
            r_ren   <= m_ren[w_win];
            r_wen   <= m_wen[w_win];
            r_addr  <= m_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= m_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
            r_width <= m_width[w_win*2 +: 2];
        end else if (w_busy && !w_done) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Ack wins over the timeout in the last allowed cycle, so the timeout error needs !s_ack.
    assign m_ack    = (w_busy && s_ack) ? w_onehot : '0;
    assign m_err    = (w_busy && (s_err || (!s_ack && w_tmo))) ? w_onehot : '0;
    assign m_rdata  = (w_busy && s_ack) ? s_rdata : '0;
    assign s_sel    = w_busy;
    assign busy     = w_busy;
    assign s_ren    = r_ren;
    assign s_wen    = r_wen;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign s_width  = r_width;
    assign grant_id = r_gid;
endmodule

// File: tb/tb_minibus_arbiter.sv
// tb_minibus_arbiter: random masters and slave against a transaction-level round-robin model;
// a scoreboard monitor checks grants, held downstream fields and routed responses.
module tb_minibus_arbiter;
    localparam int N = 4, AW = 32, DW = 32, TO = 16;

    typedef struct {
        int id;
        logic ren, wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0] width;
    } txn_t;

    typedef struct {
        int id;
        logic a, e;
        logic [DW-1:0] rdata;
        int cyc;
    } rsp_t;

    logic clk = 1'b0, nrst = 1'b0;
    logic [N-1:0] m_ren, m_wen, m_ack, m_err;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*2-1:0] m_width;
    logic [DW-1:0] m_rdata, s_wdata, s_rdata;
    logic [AW-1:0] s_addr;
    logic [1:0] s_width, grant_id;
    logic s_sel, s_ren, s_wen, s_ack, s_err, busy;

    minibus_arbiter #(.N_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst), .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_width(m_width), .m_ack(m_ack), .m_err(m_err),
        .m_rdata(m_rdata), .s_sel(s_sel), .s_ren(s_ren), .s_wen(s_wen),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_width(s_width), .s_ack(s_ack),
        .s_err(s_err), .s_rdata(s_rdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    txn_t exp_q[$];
    rsp_t rsp_q[$];
    int n_chk = 0, n_fail = 0;
    bit mon_en = 1'b0;

    logic [N-1:0] pend = '0, wd = '0;
    logic mr[N], mw[N];
    logic [AW-1:0] ma[N];
    logic [DW-1:0] md[N];
    logic [1:0] mz[N];

    logic [N-1:0] rmask = '0;
    int prob = 0, mut_pct = 0;
    bit f_on = 1'b0, f_a = 1'b0, f_e = 1'b0, f_mut = 1'b0;
    int f_lat = 2;
    logic [DW-1:0] f_rd = '0;

    int mdl_last = N - 1;
    int sb = 0, p_lat = 0;
    bit p_a = 1'b0, p_e = 1'b0;
    logic [DW-1:0] p_rd = '0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic new_req(int i, logic rn, logic wn, logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] z);
        pend[i] = 1'b1;
        wd[i] = 1'b0;
        mr[i] = rn;
        mw[i] = wn;
        ma[i] = a;
        md[i] = d;
        mz[i] = z;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            m_ren[i] = pend[i] && !wd[i] && mr[i];
            m_wen[i] = pend[i] && !wd[i] && mw[i];
            m_addr[i*AW +: AW] = ma[i];
            m_wdata[i*DW +: DW] = md[i];
            m_width[i*2 +: 2] = mz[i];
        end
    endtask

    // One bus cycle: masters react to last cycle's response, slave acts, model predicts the grant.
    task automatic step();
        logic [N-1:0] rsp, req;
        int r, w;
        rsp_t x;
        bit to;
        @(negedge clk);
        rsp = m_ack | m_err;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rsp[i]) begin
                pend[i] = 1'b0;
                wd[i] = 1'b0;
            end
            if (!pend[i] && rmask[i] && $urandom_range(99) < prob) begin
                r = $urandom_range(19);
                new_req(i, r < 10 || r == 19, r >= 10, $urandom, $urandom, 2'($urandom_range(2)));
            end
        end
        if (s_sel) begin
            sb++;
            if (sb == 1) begin
                if (f_mut) begin
                    ma[mdl_last] = '0;
                    md[mdl_last] = ~md[mdl_last];
                    mz[mdl_last] = 2'b10;
                end else if ($urandom_range(99) < mut_pct) begin
                    if ($urandom_range(1) == 0) begin
                        ma[mdl_last] = $urandom;
                        mz[mdl_last] = ~mz[mdl_last];
                    end else
                        wd[mdl_last] = 1'b1;
                end
                if (f_on) begin
                    p_lat = f_lat;
                    p_a = f_a;
                    p_e = f_e;
                    p_rd = f_rd;
                end else begin
                    p_lat = $urandom_range(TO + 2, 1);
                    r = $urandom_range(7);
                    p_a = r < 5 || r == 6;
                    p_e = r == 5 || r == 6;
                    p_rd = $urandom;
                end
                if (s_ren && s_wen) begin
                    p_a = 1'b0;
                    p_e = 1'b0;
                end
                to = (!p_a && !p_e) || p_lat > TO;
                x.id = mdl_last;
                x.a = !to && p_a;
                x.e = to || p_e;
                x.cyc = to ? TO : p_lat;
                x.rdata = x.a ? p_rd : '0;
                rsp_q.push_back(x);
            end
            s_ack = sb == p_lat && p_a;
            s_err = sb == p_lat && p_e;
            s_rdata = sb == p_lat ? p_rd : DW'($urandom);
        end else begin
            sb = 0;
            s_ack = $urandom_range(3) == 0;
            s_err = $urandom_range(3) == 0;
            s_rdata = $urandom;
        end
        drive();
        req = m_ren | m_wen;
        if (!s_sel && req != '0) begin
            w = mdl_last;
            for (int k = 1; k <= N; k++) begin
                w = (mdl_last + k) % N;
                if (req[w]) break;
            end
            exp_q.push_back('{w, mr[w], mw[w], ma[w], md[w], mz[w]});
            mdl_last = w;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((pend != '0 || s_sel) && n < 200) begin
            step();
            n++;
        end
        step();
        chk("drain_bounded", n < 200, 1'b1);
    endtask

    task automatic force_rsp(int lat, bit a, bit e, logic [DW-1:0] rd);
        f_on = 1'b1;
        f_lat = lat;
        f_a = a;
        f_e = e;
        f_rd = rd;
    endtask

    txn_t cur;
    rsp_t rr;
    int bcnt = 0, qprev = 0;
    bit prev_sel = 1'b0, prev_resp = 1'b0;
    logic [N-1:0] ea, ee;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_sel = 1'b0;
            prev_resp = 1'b0;
            qprev = 0;
            bcnt = 0;
        end else begin
            if (s_sel && !prev_sel) begin
                bcnt = 0;
                if (exp_q.size() == 0)
                    chk("grant_unexpected", grant_id, 4'hf);
                else
                    cur = exp_q.pop_front();
            end else if (!s_sel && qprev > 0) begin
                chk("grant_missing", s_sel, 1'b1);
                void'(exp_q.pop_front());
            end
            if (s_sel) begin
                bcnt++;
                chk("s_fields", {busy, grant_id, s_ren, s_wen, s_width, s_addr, s_wdata},
                    {1'b1, 2'(cur.id), cur.ren, cur.wen, cur.width, cur.addr, cur.wdata});
            end else
                chk("idle_busy", busy, 1'b0);
            if ((m_ack | m_err) != '0) begin
                if (!s_sel)
                    chk("resp_outside_busy", {m_ack, m_err}, '0);
                else if (rsp_q.size() == 0)
                    chk("resp_unexpected", {m_ack, m_err}, '0);
                else begin
                    rr = rsp_q.pop_front();
                    ea = '0;
                    ee = '0;
                    ea[rr.id] = rr.a;
                    ee[rr.id] = rr.e;
                    chk("resp_ack", m_ack, ea);
                    chk("resp_err", m_err, ee);
                    chk("resp_rdata", m_rdata, rr.rdata);
                    chk("resp_cycle", bcnt, rr.cyc);
                end
            end else begin
                if (s_sel && bcnt > TO) chk("resp_overdue", bcnt, TO);
                if (s_rdata != '0) chk("rdata_zero_without_ack", m_rdata, '0);
            end
            if (prev_resp && s_sel) chk("sel_after_resp", s_sel, 1'b0);
            prev_resp = s_sel && (m_ack | m_err) != '0;
            prev_sel = s_sel;
            qprev = exp_q.size();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) new_req(i, 1'b1, 1'b1, $urandom, $urandom, 2'b01);
        drive();
        pend = '0;
        s_ack = 1'b1;
        s_err = 1'b1;
        s_rdata = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sel_busy", {s_sel, busy}, '0);
        chk("reset_grant_id", grant_id, '0);
        chk("reset_s_fields", {s_ren, s_wen, s_width, s_addr, s_wdata}, '0);
        chk("reset_resp", {m_ack, m_err, m_rdata}, '0);
        drive();
        s_ack = 1'b0;
        s_err = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        mon_en = 1'b1;

        force_rsp(2, 1'b1, 1'b0, 32'h0);
        rmask = 4'b0101;
        prob = 100;
        repeat (6) step();
        rmask = 4'b1101;
        repeat (12) step();
        rmask = '0;
        prob = 0;
        drain();

        new_req(1, 1'b1, 1'b0, 32'h8, 32'h0, 2'b10);
        force_rsp(2, 1'b1, 1'b0, 32'hDEADBEEF);
        drain();
        new_req(1, 1'b0, 1'b1, 32'h5, 32'hAB, 2'b00);
        f_mut = 1'b1;
        force_rsp(4, 1'b1, 1'b0, 32'h0);
        drain();
        f_mut = 1'b0;
        new_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
        force_rsp(2, 1'b0, 1'b1, 32'hCAFE_F00D);
        drain();
        new_req(3, 1'b1, 1'b0, 32'h44, 32'h0, 2'b01);
        force_rsp(2, 1'b1, 1'b1, 32'h5555_AAAA);
        drain();
        new_req(2, 1'b1, 1'b0, 32'h80, 32'h0, 2'b10);
        force_rsp(TO, 1'b1, 1'b0, 32'h0BAD_F00D);
        drain();
        new_req(2, 1'b1, 1'b0, 32'h90, 32'h0, 2'b10);
        new_req(3, 1'b0, 1'b1, 32'h94, 32'h77, 2'b10);
        force_rsp(TO + 5, 1'b0, 1'b0, 32'h0);
        drain();

        f_on = 1'b0;
        rmask = '1;
        prob = 30;
        mut_pct = 10;
        repeat (3000) step();
        rmask = '0;
        prob = 0;
        mut_pct = 0;
        drain();

        new_req(2, 1'b1, 1'b0, 32'hA0, 32'h0, 2'b10);
        force_rsp(TO + 5, 1'b0, 1'b0, 32'h0);
        n = 0;
        while (!s_sel && n < 10) begin
            step();
            n++;
        end
        chk("rst_mid_granted", s_sel, 1'b1);
        mon_en = 1'b0;
        s_ack = 1'b1;
        s_err = 1'b1;
        #1 nrst = 1'b0;
        #1;
        chk("rst_mid_sel_busy", {s_sel, busy}, '0);
        chk("rst_mid_resp", {m_ack, m_err}, '0);
        chk("rst_mid_grant_id", grant_id, '0);
        exp_q.delete();
        rsp_q.delete();
        pend = '0;
        wd = '0;
        sb = 0;
        mdl_last = N - 1;
        s_ack = 1'b0;
        s_err = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        mon_en = 1'b1;
        new_req(1, 1'b1, 1'b0, 32'hB1, 32'h0, 2'b10);
        new_req(0, 1'b1, 1'b0, 32'hB0, 32'h0, 2'b10);
        new_req(3, 1'b0, 1'b1, 32'hB3, 32'h3, 2'b10);
        force_rsp(2, 1'b1, 1'b0, 32'h600D_0000);
        drain();

        chk("queues_empty", {32'(exp_q.size()), 32'(rsp_q.size())}, '0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/minibus_arbiter.md
# minibus_arbiter

Round-robin arbiter that shares one minibus slave-side port among `N_MASTERS` requesters such as CPU instruction fetch, CPU data and DMA. It sits between the masters and the address decoder or slave register arrays. For each transaction it registers the winning request, holds it stable on the downstream port until the slave acks or errs, and routes the response back to the winner. A timeout counter converts a hung slave into a bus error.

## Interface
Parameters:
- `N_MASTERS`, 4: number of requesters, ≥2.
- `DATA_WIDTH`, 32: data width.
- `ADDR_WIDTH`, 32: byte address width.
- `TIMEOUT`, 16: maximum BUSY cycles before a forced error, ≥2.

Ports:
- `clk`  in  1  bus clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `m_ren`  in  N_MASTERS  per-master read request.
- `m_wen`  in  N_MASTERS  per-master write request.
- `m_addr`  in  N_MASTERS×ADDR_WIDTH  per-master byte address.
- `m_wdata`  in  N_MASTERS×DATA_WIDTH  per-master write data.
- `m_width`  in  N_MASTERS×2  per-master size: 00 byte, 01 half, 10 word.
- `m_ack`  out  N_MASTERS  one-hot completion pulse.
- `m_err`  out  N_MASTERS  one-hot error pulse.
- `m_rdata`  out  DATA_WIDTH  read data, shared; valid only with `m_ack`.
- `s_sel`  out  1  downstream select.
- `s_ren`, `s_wen`  out  1 each  downstream read and write enables.
- `s_addr`  out  ADDR_WIDTH  downstream address.
- `s_wdata`  out  DATA_WIDTH  downstream write data.
- `s_width`  out  2  downstream size.
- `s_ack`  in  1  slave acknowledge.
- `s_err`  in  1  slave error.
- `s_rdata`  in  DATA_WIDTH  slave read data.
- `grant_id`  out  clog2(N_MASTERS)  index of the current or last granted master.
- `busy`  out  1  high while in BUSY.

## Operation
- Master request: `req[i] = m_ren[i] | m_wen[i]`. A master holds its request fields stable until it sees `m_ack[i]` or `m_err[i]`.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - Arbitration is round-robin. The search starts at `(last_grant+1) mod N_MASTERS` and wraps; the first requester found wins.
  - On any request: register the winner's ren, wen, addr, wdata and width into the downstream registers. Set `grant_id` to the winner, set `last_grant` to the winner, clear the timeout counter, go to BUSY.
  - With no request: stay in IDLE, all downstream registers hold their values, `s_sel`=0.
- BUSY:
  - `s_sel`=1 and the registered fields drive `s_*`. Fields are unchanged for the whole of BUSY.
  - `s_ack`=1: `m_ack[grant_id]`=1 combinationally, `m_rdata`=`s_rdata`, go to IDLE.
  - `s_err`=1: `m_err[grant_id]`=1, go to IDLE. If `s_ack` and `s_err` are both high, both pulses are asserted.
  - Neither, with counter = TIMEOUT−1: `m_err[grant_id]`=1, go to IDLE.
  - Otherwise: increment the counter and stay in BUSY.
- Outside BUSY, `m_ack` and `m_err` are 0 and `s_ack`/`s_err` are ignored.
- `m_rdata` is `s_rdata` when `m_ack` is nonzero, otherwise 0.
- Requests withdrawn while BUSY do not abort the transaction; the response still pulses to the granted master.
- ren=wen=1 is forwarded unchanged. The slave will not ack it, so it ends in a timeout error.

## Timing
- Reset, asynchronous: state=IDLE, `last_grant`=N_MASTERS−1 (master 0 has first priority), counter=0, all `s_*` outputs=0, `grant_id`=0, `busy`=0, `m_ack`=`m_err`=0.
- Reset mid-BUSY drops `s_sel` immediately and no response is issued.
- Latency with a one-cycle slave:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `s_sel`=1.
  - Cycle 2: `s_ack` and `m_ack` high.
  - Cycle 3: IDLE with `s_sel`=0, which lets the slave clear its ready. Re-arbitration happens in this cycle.
- Peak throughput is one transaction per 3 cycles.
- The one IDLE cycle between grants is mandatory, even when the same master requests again.
- Timeout: with no slave response, `m_err` pulses in cycle TIMEOUT, counting the first `s_sel`=1 cycle as cycle 1.
- Ack in the final allowed cycle takes priority over the timeout: ack only, no err.

## Test plan
- Single master 1, word read of 0x8, slave returns 0xDEADBEEF with ack in cycle 2 -> `m_ack`=4'b0010 in cycle 2, `m_rdata`=0xDEADBEEF, `s_sel` low in cycle 3.
- Masters 0 and 2 request simultaneously and continuously after reset -> grants 0,2,0,2 with `s_sel` high in cycles 1,4,7,10. Add master 3 at the third grant -> order becomes 0,2,3,0.
- Master 1 byte write, addr 0x5, wdata 0xAB; master changes `m_addr` to 0x0 during BUSY -> `s_addr` stays 0x5 and `s_width`=00 until ack.
- Slave never responds, TIMEOUT=16 -> `m_err[grant]` single pulse in cycle 16, `s_sel` low in cycle 17, next requester then granted.
- Slave asserts `s_err` in cycle 2 -> `m_err` pulse only, `m_ack`=0. Separately, ack arriving in cycle 16 with TIMEOUT=16 -> `m_ack`=1, `m_err`=0.
- `nrst` low in BUSY cycle 1 -> `s_sel`=0, `busy`=0, no ack. After release, master 0 wins first.
